// File: rtl/rfa_serial_ctrl.sv
// Bit-serial adder controller: feeds one shared reversible full-adder cell LSB first and
// checks that the cell hands its a/b inputs back unchanged.
module rfa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_a_out,
  input  logic             fa_b_out,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] a_keep,
  output logic [WIDTH-1:0] b_keep,
  output logic             busy,
  output logic             pres_err
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] a_keep_reg;
  logic [WIDTH-1:0] b_keep_reg;
  logic             cout_reg;
  logic             pres_err_reg;

  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] a_keep_next;
  logic [WIDTH-1:0] b_keep_next;
  logic             run_st;

  // One-hot decode of the current bit index; selects nothing once idx reaches WIDTH.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sel
      assign bit_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign run_st = (state_reg == RUN);

  assign fa_a   = run_st & (|(a_reg & bit_sel));
  assign fa_b   = run_st & (|(b_reg & bit_sel));
  assign fa_cin = run_st & carry_reg;

  assign sum_next    = (sum_reg    & ~bit_sel) | ({WIDTH{fa_sum}}   & bit_sel);
  assign a_keep_next = (a_keep_reg & ~bit_sel) | ({WIDTH{fa_a_out}} & bit_sel);
  assign b_keep_next = (b_keep_reg & ~bit_sel) | ({WIDTH{fa_b_out}} & bit_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      sum_reg      <= '0;
      a_keep_reg   <= '0;
      b_keep_reg   <= '0;
      cout_reg     <= 1'b0;
      pres_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            a_reg        <= a_in;
            b_reg        <= b_in;
            carry_reg    <= cin;
            idx_reg      <= '0;
            pres_err_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          sum_reg    <= sum_next;
          a_keep_reg <= a_keep_next;
          b_keep_reg <= b_keep_next;
          carry_reg  <= fa_cout;
          idx_reg    <= idx_reg + IDX_W'(1);
          if ((fa_a_out != fa_a) || (fa_b_out != fa_b)) begin
            pres_err_reg <= 1'b1;
          end
          if (idx_reg == LAST_IDX) begin
            cout_reg  <= fa_cout;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign res_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign sum         = sum_reg;
  assign cout        = cout_reg;
  assign a_keep      = a_keep_reg;
  assign b_keep      = b_keep_reg;
  assign pres_err    = pres_err_reg;

endmodule
